// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream requester bundle plus the UART transmitter handshake shared by the arbiter.
// The master modport is the arbiter's view; the slave modport is the requesters' and UART's view.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 3
) ();
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ack;
    logic [7:0]        uart_tx_dat;
    logic              uart_tx_send;
    logic              uart_tx_ready;

    modport master (
        input  req_valid, req_data, req_last, uart_tx_ready,
        output req_ack, uart_tx_dat, uart_tx_send
    );

    modport slave (
        output req_valid, req_data, req_last, uart_tx_ready,
        input  req_ack, uart_tx_dat, uart_tx_send
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among NREQ byte streams.
// A grant holds until the packet's last byte, MAX_PKT bytes, or a STALL_LIMIT-cycle requester stall.
module uart_tx_arbiter #(
    parameter int NREQ         = 3,
    parameter int MAX_PKT      = 64,
    parameter int STALL_LIMIT  = 1024,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.master   bus,
    output logic [NREQ-1:0]     grant,
    output logic [3:0]          debug_state
);
    localparam int PTR_W   = $clog2(NREQ);
    localparam int CNT_W   = $clog2(MAX_PKT + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam int BUSY_W  = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [NREQ-1:0]    grant_nx;
    logic [NREQ-1:0]    ack_q, ack_nx;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nx;
    logic [PTR_W-1:0]   owner, owner_nx;
    logic [CNT_W-1:0]   byte_cnt, byte_cnt_nx;
    logic [STALL_W-1:0] stall_cnt, stall_cnt_nx;
    logic [BUSY_W-1:0]  busy_cnt, busy_cnt_nx;
    logic               last_q, last_nx;
    logic               send_q, send_nx;
    logic [7:0]         dat_q, dat_nx;
    logic               release_grant;

    logic [NREQ-1:0]    valid_rot;
    logic [PTR_W-1:0]   pick_ofs, pick;
    logic [PTR_W:0]     pick_sum;
    logic               found;

    logic [7:0]         owner_byte;
    logic               owner_valid, owner_last;

    assign owner_byte  = bus.req_data[{owner, 3'b000} +: 8];
    assign owner_valid = bus.req_valid[owner];
    assign owner_last  = bus.req_last[owner];

    // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit then wins.
    assign valid_rot = NREQ'({bus.req_valid, bus.req_valid} >> rr_ptr);

    always_comb begin
        found    = 1'b0;
        pick_ofs = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                found    = 1'b1;
                pick_ofs = PTR_W'(k);
            end
        end
    end

    assign pick_sum = {1'b0, rr_ptr} + {1'b0, pick_ofs};
    assign pick     = (pick_sum >= (PTR_W+1)'(NREQ)) ? PTR_W'(pick_sum - (PTR_W+1)'(NREQ))
                                                     : PTR_W'(pick_sum);

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        rr_ptr_nx     = rr_ptr;
        owner_nx      = owner;
        byte_cnt_nx   = byte_cnt;
        stall_cnt_nx  = stall_cnt;
        busy_cnt_nx   = busy_cnt;
        last_nx       = last_q;
        dat_nx        = dat_q;
        send_nx       = 1'b0;
        ack_nx        = '0;
        release_grant = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    owner_nx     = pick;
                    grant_nx     = NREQ'(1) << pick;
                    byte_cnt_nx  = '0;
                    stall_cnt_nx = '0;
                    state_nx     = SEND;
                end
            end
            SEND: begin
                if (owner_valid) begin
                    // Ready low with data present is back-pressure, not a stall.
                    if (bus.uart_tx_ready) begin
                        dat_nx       = owner_byte;
                        send_nx      = 1'b1;
                        ack_nx       = grant;
                        last_nx      = owner_last;
                        stall_cnt_nx = '0;
                        busy_cnt_nx  = '0;
                        if (byte_cnt != CNT_W'(MAX_PKT))
                            byte_cnt_nx = byte_cnt + 1'b1;
                        state_nx     = WAIT_BUSY;
                    end
                end else begin
                    if (stall_cnt != STALL_W'(STALL_LIMIT))
                        stall_cnt_nx = stall_cnt + 1'b1;
                    if (stall_cnt_nx == STALL_W'(STALL_LIMIT))
                        release_grant = 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (!bus.uart_tx_ready || (busy_cnt + 1'b1) == BUSY_W'(BUSY_TIMEOUT))
                    state_nx = WAIT_DONE;
                else
                    busy_cnt_nx = busy_cnt + 1'b1;
            end
            WAIT_DONE: begin
                if (bus.uart_tx_ready) begin
                    if (last_q || byte_cnt == CNT_W'(MAX_PKT))
                        release_grant = 1'b1;
                    else
                        state_nx = SEND;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (release_grant) begin
            grant_nx  = '0;
            rr_ptr_nx = (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;
            state_nx  = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
            byte_cnt  <= '0;
            stall_cnt <= '0;
            busy_cnt  <= '0;
            last_q    <= 1'b0;
            dat_q     <= '0;
            send_q    <= 1'b0;
            ack_q     <= '0;
        end else begin
            state     <= state_nx;
            grant     <= grant_nx;
            rr_ptr    <= rr_ptr_nx;
            owner     <= owner_nx;
            byte_cnt  <= byte_cnt_nx;
            stall_cnt <= stall_cnt_nx;
            busy_cnt  <= busy_cnt_nx;
            last_q    <= last_nx;
            dat_q     <= dat_nx;
            send_q    <= send_nx;
            ack_q     <= ack_nx;
        end
    end

    assign bus.req_ack      = ack_q;
    assign bus.uart_tx_dat  = dat_q;
    assign bus.uart_tx_send = send_q;
    assign debug_state      = {2'b00, state};
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requester queues and a UART busy model drive the DUT,
// and a packet-level round-robin model predicts the order of bytes on the UART.
module tb_uart_tx_arbiter;
    localparam int NREQ         = 3;
    localparam int MAX_PKT      = 4;
    localparam int STALL_LIMIT  = 16;
    localparam int BUSY_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0] grant;
    logic [3:0]      debug_state;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NREQ(NREQ), .MAX_PKT(MAX_PKT), .STALL_LIMIT(STALL_LIMIT), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .grant(grant), .debug_state(debug_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] src_q [NREQ][$];   // {last, data} still to be presented
    logic [8:0] mdl_q [NREQ][$];   // same traffic, consumed by the model
    int         exp_q [$];         // (requester << 8) | byte, in UART order
    int         mdl_ptr   = 0;
    int         busy      = 0;
    int         busy_len  = 10;
    bit         busy_rand = 1'b0;
    int         stall_run = 0;
    logic [NREQ-1:0] prev_grant = '0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic load(input int r, input logic [7:0] d, input bit last);
        src_q[r].push_back({last, d});
        mdl_q[r].push_back({last, d});
    endtask

    // Packet-level round robin: take bytes until last, MAX_PKT, or the stream runs dry.
    task automatic predict();
        int g;
        int n;
        logic [8:0] e;
        while (1) begin
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && mdl_q[(mdl_ptr + k) % NREQ].size() > 0) g = (mdl_ptr + k) % NREQ;
            if (g < 0) break;
            n = 0;
            do begin
                e = mdl_q[g].pop_front();
                exp_q.push_back((g << 8) | int'(e[7:0]));
                n++;
            end while (!e[8] && n < MAX_PKT && mdl_q[g].size() > 0);
            mdl_ptr = (g + 1) % NREQ;
        end
    endtask

    function automatic bit src_empty();
        bit empty = 1'b1;
        for (int r = 0; r < NREQ; r++) if (src_q[r].size() > 0) empty = 1'b0;
        return empty;
    endfunction

    task automatic clear_all();
        for (int r = 0; r < NREQ; r++) begin
            src_q[r].delete();
            mdl_q[r].delete();
        end
        exp_q.delete();
        busy              = 0;
        stall_run         = 0;
        prev_grant        = '0;
        bus.req_valid     = '0;
        bus.req_data      = '0;
        bus.req_last      = '0;
        bus.uart_tx_ready = 1'b1;
    endtask

    // One clock: observe at the falling edge, then update the UART model and requesters.
    task automatic step();
        int e;
        @(negedge clk);
        if (bus.uart_tx_send) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = -1;
            check("send_ack",   int'(bus.req_ack),     (e < 0) ? 0 : (1 << (e >> 8)));
            check("send_grant", int'(grant),           (e < 0) ? 0 : (1 << (e >> 8)));
            check("send_dat",   int'(bus.uart_tx_dat), (e < 0) ? -1 : (e & 255));
            stall_run = 0;
        end else if (bus.req_ack != '0) begin
            check("ack_without_send", int'(bus.req_ack), 0);
        end

        if (prev_grant != '0 && grant == '0) begin
            if (stall_run != 0) check("stall_len", stall_run, STALL_LIMIT);
            stall_run = 0;
        end
        if (debug_state == 4'd1 && grant != '0 && (grant & bus.req_valid) == '0) stall_run++;
        prev_grant = grant;

        if (bus.uart_tx_send) busy = busy_rand ? int'($urandom_range(0, 12)) : busy_len;
        else if (busy > 0) busy--;
        bus.uart_tx_ready = (busy == 0);

        for (int r = 0; r < NREQ; r++) begin
            if (bus.req_ack[r]) begin
                if (src_q[r].size() > 0) void'(src_q[r].pop_front());
                bus.req_valid[r]         = 1'b0;
                bus.req_last[r]          = 1'b0;
                bus.req_data[8*r +: 8]   = 8'h00;
            end else if (src_q[r].size() > 0) begin
                bus.req_valid[r]         = 1'b1;
                bus.req_last[r]          = src_q[r][0][8];
                bus.req_data[8*r +: 8]   = src_q[r][0][7:0];
            end else begin
                bus.req_valid[r]         = 1'b0;
                bus.req_last[r]          = 1'b0;
                bus.req_data[8*r +: 8]   = 8'h00;
            end
        end
    endtask

    task automatic run(input string tag);
        int cyc = 0;
        bit done = 1'b0;
        while (!done && cyc < 3000) begin
            step();
            cyc++;
            done = (exp_q.size() == 0) && src_empty() && grant == '0 && debug_state == 4'd0;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_idle"}, int'(grant), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;
        bus.req_valid     = '0;
        bus.req_data      = '0;
        bus.req_last      = '0;
        bus.uart_tx_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_grant", int'(grant), 0);
        check("rst_send",  int'(bus.uart_tx_send), 0);
        check("rst_ack",   int'(bus.req_ack), 0);
        check("rst_dat",   int'(bus.uart_tx_dat), 0);
        check("rst_state", int'(debug_state), 0);
        rst = 1'b0;

        // Two packets contending straight out of reset.
        load(0, 8'h41, 1'b0); load(0, 8'h42, 1'b1);
        load(1, 8'h43, 1'b0); load(1, 8'h44, 1'b1);
        predict();
        run("compete");

        // Single byte with idle-to-grant and idle-to-strobe latency.
        load(0, 8'h41, 1'b1);
        predict();
        step();
        step();
        check("lat_grant", int'(grant), 1);
        check("lat_nosend", int'(bus.uart_tx_send), 0);
        step();
        check("lat_send", int'(bus.uart_tx_send), 1);
        run("single");

        // Everyone streaming one-byte packets.
        for (int rep = 0; rep < 2; rep++)
            for (int r = 0; r < NREQ; r++) load(r, 8'(8'h30 + 3*rep + r), 1'b1);
        predict();
        run("rr");

        load(1, 8'h55, 1'b1);
        predict();
        run("ptr_move");

        // Oversized packet from requester 2 while requester 0 waits.
        for (int i = 0; i < 6; i++) load(2, 8'(8'h60 + i), 1'b0);
        load(0, 8'h70, 1'b0); load(0, 8'h71, 1'b1);
        predict();
        run("max_pkt");

        // Requester 1 goes quiet mid-packet.
        load(1, 8'h80, 1'b0);
        load(2, 8'h90, 1'b1);
        predict();
        run("stall");

        // Ready never drops after a send.
        busy_len = 0;
        load(0, 8'hC1, 1'b0); load(0, 8'hC2, 1'b0); load(0, 8'hC3, 1'b1);
        predict();
        run("ready_high");

        busy_rand = 1'b1;
        for (int round = 0; round < 8; round++) begin
            for (int r = 0; r < NREQ; r++) begin
                n = int'($urandom_range(0, 5));
                for (int b = 0; b < n; b++)
                    load(r, 8'($urandom), (b == n - 1) ? ($urandom_range(0, 3) != 0)
                                                       : ($urandom_range(0, 4) == 0));
            end
            predict();
            run("random");
        end
        busy_rand = 1'b0;
        busy_len  = 8;

        // Reset while a packet is in flight, with rr_ptr away from zero.
        load(0, 8'h11, 1'b1);
        predict();
        run("pre_reset");
        load(2, 8'hA5, 1'b0); load(2, 8'h5A, 1'b0); load(2, 8'h3C, 1'b1);
        predict();
        cyc = 0;
        while (cyc < 100 && !(debug_state == 4'd3 && exp_q.size() == 2)) begin
            step();
            cyc++;
        end
        check("rst_setup_state", int'(debug_state), 3);
        rst = 1'b1;
        #1;
        check("arst_grant", int'(grant), 0);
        check("arst_send",  int'(bus.uart_tx_send), 0);
        check("arst_ack",   int'(bus.req_ack), 0);
        check("arst_dat",   int'(bus.uart_tx_dat), 0);
        check("arst_state", int'(debug_state), 0);
        clear_all();
        mdl_ptr = 0;
        step();
        step();
        rst = 1'b0;
        repeat (20) step();
        check("post_rst_grant", int'(grant), 0);
        for (int r = 0; r < NREQ; r++) load(r, 8'(8'hD0 + r), 1'b1);
        predict();
        run("after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
